// File: rtl/load_unit_pkg.sv
//------------------------------------------------------------------------------
// Module   : load_unit_pkg
// Brief    : Load-type encodings, FSM state type and alignment helper for load_unit.
// Revision : 1.0
//------------------------------------------------------------------------------
`default_nettype none

package load_unit_pkg;

    localparam logic [2:0] c_F3_LB  = 3'b000;
    localparam logic [2:0] c_F3_LH  = 3'b001;
    localparam logic [2:0] c_F3_LW  = 3'b010;
    localparam logic [2:0] c_F3_LBU = 3'b100;
    localparam logic [2:0] c_F3_LHU = 3'b101;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_RESP = 2'd2
    } lu_state_t;

    // Unlisted funct3 codes behave as word loads.
    function automatic logic f_misaligned(input logic [2:0] f3, input logic [1:0] off);
        case (f3)
            c_F3_LB, c_F3_LBU: f_misaligned = 1'b0;
            c_F3_LH, c_F3_LHU: f_misaligned = off[0];
            default:           f_misaligned = (off != 2'b00);
        endcase
    endfunction

endpackage

`default_nettype wire

// File: rtl/load_unit_align.sv
//------------------------------------------------------------------------------
// Module   : load_align
// Brief    : Byte/halfword/word select from a read word plus sign/zero extension.
// Revision : 1.0
//------------------------------------------------------------------------------
`default_nettype none

module load_align
    import load_unit_pkg::*;
(
    input  logic [2:0]  i_funct3,
    input  logic [1:0]  i_offset,
    input  logic [31:0] i_data,
    output logic [31:0] o_result
);

    logic [7:0]  w_byte;
    logic [15:0] w_half;

    always_comb begin
        case (i_offset)
            2'd0:    w_byte = i_data[7:0];
            2'd1:    w_byte = i_data[15:8];
            2'd2:    w_byte = i_data[23:16];
            default: w_byte = i_data[31:24];
        endcase
        w_half = i_offset[1] ? i_data[31:16] : i_data[15:0];
    end

    always_comb begin
        case (i_funct3)
            c_F3_LB:  o_result = {{24{w_byte[7]}}, w_byte};
            c_F3_LBU: o_result = {24'h000000, w_byte};
            c_F3_LH:  o_result = {{16{w_half[15]}}, w_half};
            c_F3_LHU: o_result = {16'h0000, w_half};
            default:  o_result = i_data;
        endcase
    end

endmodule

`default_nettype wire

// File: rtl/load_unit.sv
//------------------------------------------------------------------------------
// Module   : load_unit
// Brief    : Issues aligned data-memory reads for loads, extracts and extends the
//            result, stalls while outstanding and flags bus timeouts.
//            Optional misaligned-load trap: define LOAD_MISALIGN_TRAP_EN.
// Revision : 1.0
//------------------------------------------------------------------------------
`default_nettype none

module load_unit
    import load_unit_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 16
) (
    input  logic        clk_in,
    input  logic        reset_in,
    input  logic [2:0]  funct3_in,
    input  logic [31:0] iadder_in,
    input  logic        mem_rd_req_in,
    input  logic [31:0] dmdata_in,
    input  logic        dm_ack_in,
    output logic [31:0] dmaddr_out,
    output logic        dmrd_req_out,
    output logic [31:0] lu_output_out,
    output logic        lu_valid_out,
    output logic        stall_out,
    output logic        bus_err_out,
    output logic        misaligned_out
);

    localparam int c_CNT_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [c_CNT_W-1:0] c_CNT_LAST =
        c_CNT_W'((TIMEOUT_CYCLES == 0) ? 0 : TIMEOUT_CYCLES - 1);

    lu_state_t          r_state, w_state_nxt;
    logic [2:0]         r_funct3, w_funct3_nxt;
    logic [1:0]         r_offset, w_offset_nxt;
    logic [31:0]        r_dmaddr, w_dmaddr_nxt;
    logic               r_rd_req, w_rd_req_nxt;
    logic [31:0]        r_lu_out, w_lu_out_nxt;
    logic               r_lu_valid, w_lu_valid_nxt;
    logic               r_bus_err, w_bus_err_nxt;
    logic               r_misaligned, w_misaligned_nxt;
    logic [c_CNT_W-1:0] r_cnt, w_cnt_nxt;

    logic               w_misaligned;
    logic               w_timeout;
    logic [31:0]        w_aligned;

`ifdef LOAD_MISALIGN_TRAP_EN
    assign w_misaligned = f_misaligned(funct3_in, iadder_in[1:0]);
`else
    assign w_misaligned = 1'b0;
`endif

    assign w_timeout = (TIMEOUT_CYCLES != 0) && (r_cnt == c_CNT_LAST);

    load_align u_load_align (
        .i_funct3 (r_funct3),
        .i_offset (r_offset),
        .i_data   (dmdata_in),
        .o_result (w_aligned)
    );

    always_comb begin
        w_state_nxt      = r_state;
        w_funct3_nxt     = r_funct3;
        w_offset_nxt     = r_offset;
        w_dmaddr_nxt     = r_dmaddr;
        w_rd_req_nxt     = r_rd_req;
        w_lu_out_nxt     = r_lu_out;
        w_lu_valid_nxt   = 1'b0;
        w_bus_err_nxt    = 1'b0;
        w_misaligned_nxt = 1'b0;
        w_cnt_nxt        = r_cnt;

        case (r_state)
            ST_IDLE: begin
                if (mem_rd_req_in) begin
                    if (w_misaligned) begin
                        w_misaligned_nxt = 1'b1;
                    end else begin
                        w_funct3_nxt = funct3_in;
                        w_offset_nxt = iadder_in[1:0];
                        w_dmaddr_nxt = {iadder_in[31:2], 2'b00};
                        w_rd_req_nxt = 1'b1;
                        w_cnt_nxt    = '0;
                        w_state_nxt  = ST_WAIT;
                    end
                end
            end
            ST_WAIT: begin
                if (dm_ack_in) begin
                    w_lu_out_nxt   = w_aligned;
                    w_lu_valid_nxt = 1'b1;
                    w_rd_req_nxt   = 1'b0;
                    w_cnt_nxt      = '0;
                    w_state_nxt    = ST_RESP;
                end else if (w_timeout) begin
                    w_bus_err_nxt = 1'b1;
                    w_rd_req_nxt  = 1'b0;
                    w_cnt_nxt     = '0;
                    w_state_nxt   = ST_IDLE;
                end else if (TIMEOUT_CYCLES != 0) begin
                    w_cnt_nxt = r_cnt + c_CNT_W'(1);
                end
            end
            // The pipeline advances on this edge, so a request seen here is not ours.
            ST_RESP: w_state_nxt = ST_IDLE;
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk_in) begin
        if (reset_in) begin
            r_state      <= ST_IDLE;
            r_funct3     <= 3'b000;
            r_offset     <= 2'b00;
            r_dmaddr     <= 32'h0;
            r_rd_req     <= 1'b0;
            r_lu_out     <= 32'h0;
            r_lu_valid   <= 1'b0;
            r_bus_err    <= 1'b0;
            r_misaligned <= 1'b0;
            r_cnt        <= '0;
        end else begin
            r_state      <= w_state_nxt;
            r_funct3     <= w_funct3_nxt;
            r_offset     <= w_offset_nxt;
            r_dmaddr     <= w_dmaddr_nxt;
            r_rd_req     <= w_rd_req_nxt;
            r_lu_out     <= w_lu_out_nxt;
            r_lu_valid   <= w_lu_valid_nxt;
            r_bus_err    <= w_bus_err_nxt;
            r_misaligned <= w_misaligned_nxt;
            r_cnt        <= w_cnt_nxt;
        end
    end

    assign dmaddr_out     = r_dmaddr;
    assign dmrd_req_out   = r_rd_req;
    assign lu_output_out  = r_lu_out;
    assign lu_valid_out   = r_lu_valid;
    assign bus_err_out    = r_bus_err;
    assign misaligned_out = r_misaligned;
    assign stall_out      = ((r_state == ST_IDLE) && mem_rd_req_in && !w_misaligned)
                          || (r_state == ST_WAIT);

endmodule

`default_nettype wire

// File: tb/tb_load_unit.sv
//------------------------------------------------------------------------------
// Module   : tb_load_unit
// Brief    : Directed self-checking bench for load_unit (timeout set to 4 cycles).
// Revision : 1.0
//------------------------------------------------------------------------------
`default_nettype none

module tb_load_unit;

    logic        clk_in = 1'b0;
    logic        reset_in = 1'b1;
    logic [2:0]  funct3_in = 3'b000;
    logic [31:0] iadder_in = 32'h0;
    logic        mem_rd_req_in = 1'b0;
    logic [31:0] dmdata_in = 32'h0;
    logic        dm_ack_in = 1'b0;
    logic [31:0] dmaddr_out;
    logic        dmrd_req_out;
    logic [31:0] lu_output_out;
    logic        lu_valid_out;
    logic        stall_out;
    logic        bus_err_out;
    logic        misaligned_out;

    int n_vec = 0;
    int n_err = 0;
    int stall_cnt = 0;
    int valid_cnt = 0;
    int buserr_cnt = 0;

    load_unit #(.TIMEOUT_CYCLES(4)) dut (
        .clk_in         (clk_in),
        .reset_in       (reset_in),
        .funct3_in      (funct3_in),
        .iadder_in      (iadder_in),
        .mem_rd_req_in  (mem_rd_req_in),
        .dmdata_in      (dmdata_in),
        .dm_ack_in      (dm_ack_in),
        .dmaddr_out     (dmaddr_out),
        .dmrd_req_out   (dmrd_req_out),
        .lu_output_out  (lu_output_out),
        .lu_valid_out   (lu_valid_out),
        .stall_out      (stall_out),
        .bus_err_out    (bus_err_out),
        .misaligned_out (misaligned_out)
    );

    always #5 clk_in = ~clk_in;

    always @(negedge clk_in) begin
        if (stall_out)    stall_cnt++;
        if (lu_valid_out) valid_cnt++;
        if (bus_err_out)  buserr_cnt++;
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk_in);
        #1;
    endtask

    task automatic run_load(input string tag, input logic [2:0] f3, input logic [31:0] addr,
                            input logic [31:0] data, input int waits,
                            input logic [31:0] exp_addr, input logic [31:0] exp_out);
        int s0, v0;
        s0 = stall_cnt;
        v0 = valid_cnt;
        funct3_in     = f3;
        iadder_in     = addr;
        mem_rd_req_in = 1'b1;
        #1;
        chk({tag, ".stall_req"}, 32'(stall_out), 32'd1);
        tick();
        chk({tag, ".rdreq"}, 32'(dmrd_req_out), 32'd1);
        chk({tag, ".addr"}, dmaddr_out, exp_addr);
        chk({tag, ".novalid"}, 32'(lu_valid_out), 32'd0);
        for (int i = 0; i < waits; i++) begin
            tick();
            chk({tag, ".addr_hold"}, dmaddr_out, exp_addr);
        end
        dm_ack_in = 1'b1;
        dmdata_in = data;
        tick();
        dm_ack_in     = 1'b0;
        dmdata_in     = 32'h0;
        mem_rd_req_in = 1'b0;
        chk({tag, ".valid"}, 32'(lu_valid_out), 32'd1);
        chk({tag, ".out"}, lu_output_out, exp_out);
        chk({tag, ".rdreq_drop"}, 32'(dmrd_req_out), 32'd0);
        tick();
        chk({tag, ".valid_end"}, 32'(lu_valid_out), 32'd0);
        chk({tag, ".valid_cnt"}, 32'(valid_cnt - v0), 32'd1);
        chk({tag, ".stall_cnt"}, 32'(stall_cnt - s0), 32'(waits + 2));
    endtask

    initial begin
        int v0, e0;
        tick();
        tick();
        chk("rst.addr", dmaddr_out, 32'h0);
        chk("rst.rdreq", 32'(dmrd_req_out), 32'd0);
        chk("rst.out", lu_output_out, 32'h0);
        chk("rst.valid", 32'(lu_valid_out), 32'd0);
        chk("rst.buserr", 32'(bus_err_out), 32'd0);
        chk("rst.mis", 32'(misaligned_out), 32'd0);
        reset_in = 1'b0;
        tick();

        run_load("lb",  3'b000, 32'h0000_1003, 32'h80FF_0000, 1, 32'h0000_1000, 32'hFFFF_FF80);
        run_load("lhu", 3'b101, 32'h0000_2002, 32'h8001_1234, 0, 32'h0000_2000, 32'h0000_8001);
        run_load("lh",  3'b001, 32'h0000_2002, 32'h8001_1234, 2, 32'h0000_2000, 32'hFFFF_8001);
        run_load("lbu", 3'b100, 32'h0000_1001, 32'h1234_56F8, 0, 32'h0000_1000, 32'h0000_0056);
        run_load("lh0", 3'b001, 32'h0000_2000, 32'hFFFF_7FFF, 0, 32'h0000_2000, 32'h0000_7FFF);
        run_load("lw",  3'b010, 32'h0000_3000, 32'hCAFE_F00D, 0, 32'h0000_3000, 32'hCAFE_F00D);
        run_load("f3_7", 3'b111, 32'h0000_3004, 32'h8765_4321, 0, 32'h0000_3004, 32'h8765_4321);

        // Stray acknowledge while idle must not disturb anything.
        v0 = valid_cnt;
        dm_ack_in = 1'b1;
        dmdata_in = 32'h1111_1111;
        tick();
        tick();
        dm_ack_in = 1'b0;
        chk("stray.out", lu_output_out, 32'h8765_4321);
        chk("stray.valid", 32'(valid_cnt - v0), 32'd0);
        chk("stray.rdreq", 32'(dmrd_req_out), 32'd0);

        // Timeout after four un-acked wait cycles.
        v0 = valid_cnt;
        e0 = buserr_cnt;
        funct3_in = 3'b010;
        iadder_in = 32'h0000_5000;
        mem_rd_req_in = 1'b1;
        tick();
        mem_rd_req_in = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("to.noerr", 32'(bus_err_out), 32'd0);
            chk("to.rdreq", 32'(dmrd_req_out), 32'd1);
        end
        tick();
        chk("to.err", 32'(bus_err_out), 32'd1);
        chk("to.rdreq_drop", 32'(dmrd_req_out), 32'd0);
        chk("to.stall", 32'(stall_out), 32'd0);
        tick();
        chk("to.err_end", 32'(bus_err_out), 32'd0);
        chk("to.err_cnt", 32'(buserr_cnt - e0), 32'd1);
        chk("to.novalid", 32'(valid_cnt - v0), 32'd0);
        chk("to.out_keep", lu_output_out, 32'h8765_4321);

`ifdef LOAD_MISALIGN_TRAP_EN
        funct3_in = 3'b010;
        iadder_in = 32'h0000_4001;
        mem_rd_req_in = 1'b1;
        #1;
        chk("mis.stall", 32'(stall_out), 32'd0);
        tick();
        mem_rd_req_in = 1'b0;
        chk("mis.pulse", 32'(misaligned_out), 32'd1);
        chk("mis.rdreq", 32'(dmrd_req_out), 32'd0);
        tick();
        chk("mis.pulse_end", 32'(misaligned_out), 32'd0);
        chk("mis.rdreq2", 32'(dmrd_req_out), 32'd0);
`else
        run_load("mis", 3'b010, 32'h0000_4001, 32'hDEAD_BEEF, 0, 32'h0000_4000, 32'hDEAD_BEEF);
        chk("mis.tied", 32'(misaligned_out), 32'd0);
`endif

        // Reset while waiting for the acknowledge.
        v0 = valid_cnt;
        funct3_in = 3'b010;
        iadder_in = 32'h0000_6000;
        mem_rd_req_in = 1'b1;
        tick();
        chk("rw.rdreq", 32'(dmrd_req_out), 32'd1);
        mem_rd_req_in = 1'b0;
        reset_in = 1'b1;
        tick();
        reset_in = 1'b0;
        chk("rw.rdreq_drop", 32'(dmrd_req_out), 32'd0);
        chk("rw.stall", 32'(stall_out), 32'd0);
        dm_ack_in = 1'b1;
        dmdata_in = 32'h5555_5555;
        tick();
        dm_ack_in = 1'b0;
        chk("rw.novalid", 32'(valid_cnt - v0), 32'd0);
        chk("rw.out_clr", lu_output_out, 32'h0);
        run_load("rw.after", 3'b100, 32'h0000_6002, 32'h00AB_0000, 1, 32'h0000_6000, 32'h0000_00AB);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/load_unit.md
# load_unit

Read-side counterpart to the store unit: it accepts a load request from the memory stage, issues an aligned word read to data memory, waits for the memory acknowledge, then extracts the addressed byte, halfword or word and sign- or zero-extends it to 32 bits. It sits between the memory stage and the data-memory read port. It stalls the pipeline while a read is outstanding and flags bus timeouts.

## Interface
- TIMEOUT_CYCLES, 16: maximum WAIT cycles before a bus error is flagged; 0 disables the timeout.
- clk_in  input  1  core clock; all state updates on the rising edge.
- reset_in  input  1  synchronous, active-high reset.
- funct3_in  input  3  load type: 000 LB, 001 LH, 010 LW, 100 LBU, 101 LHU; 011/110/111 are treated as LW.
- iadder_in  input  32  byte address, possibly unaligned.
- mem_rd_req_in  input  1  load request from the memory stage; held high while stall_out is high.
- dmdata_in  input  32  read data from data memory; valid when dm_ack_in is high.
- dm_ack_in  input  1  memory read acknowledge.
- dmaddr_out  output  32  aligned word address {addr[31:2],2'b00}, registered.
- dmrd_req_out  output  1  memory read request, registered.
- lu_output_out  output  32  aligned, extended load result, registered.
- lu_valid_out  output  1  one-cycle pulse when lu_output_out is updated.
- stall_out  output  1  pipeline hold.
- bus_err_out  output  1  one-cycle pulse on timeout.
- misaligned_out  output  1  one-cycle pulse on a misaligned load; tied 0 when the trap macro is off.

## Operation
- FSM states: IDLE, WAIT, RESP.
- IDLE, mem_rd_req_in=1 and access aligned:
  - latch funct3 and iadder_in[1:0];
  - load dmaddr_out and set dmrd_req_out=1;
  - go to WAIT.
- WAIT, dm_ack_in=1:
  - extract from dmdata_in into lu_output_out;
  - clear dmrd_req_out and the timeout counter;
  - go to RESP.
- WAIT, dm_ack_in=0: count cycles. When the count reaches TIMEOUT_CYCLES (if TIMEOUT_CYCLES is non-zero), pulse bus_err_out, clear dmrd_req_out, leave lu_output_out unchanged and go to IDLE.
- RESP: lu_valid_out=1 for this cycle only, then go to IDLE. mem_rd_req_in is ignored in RESP because the pipeline advances on this edge.
- dm_ack_in outside WAIT is ignored.
- stall_out is combinational: (IDLE && mem_rd_req_in && !misaligned) || WAIT. It is low in RESP.
- Byte loads select byte offset 0..3 = dmdata_in[7:0], [15:8], [23:16], [31:24].
  - LB replicates bit 7 of the selected byte into bits 31:8; LBU zero-fills.
- Halfword loads select by offset[1]: 0 gives [15:0], 1 gives [31:16].
  - LH sign-extends from bit 15 of the selected half; LHU zero-fills.
- LW passes dmdata_in unchanged.
- Misaligned accesses are: halfword with offset[0]=1, or word with offset!=0.

## Timing
- Reset values: state IDLE; dmaddr_out 0, dmrd_req_out 0, lu_output_out 0, lu_valid_out 0, bus_err_out 0, misaligned_out 0, timeout counter 0.
- Reset during WAIT drops dmrd_req_out on the next edge and produces no lu_valid_out.
- Minimum latency, request accepted at edge T:
  - dmrd_req_out high after T;
  - ack sampled at T+1;
  - lu_valid_out high in the cycle after T+1;
  - three cycles in total from request to result.
- dmaddr_out is stable for the whole time dmrd_req_out is high.
- lu_output_out holds its value until the next ack.
- Timeout: bus_err_out pulses in the cycle following the TIMEOUT_CYCLES-th un-acked WAIT cycle.

## Configuration
- LOAD_MISALIGN_TRAP_EN defined:
  - a misaligned request in IDLE issues no bus read and stall_out stays low;
  - misaligned_out pulses for one cycle after the accept edge;
  - state stays IDLE.
- LOAD_MISALIGN_TRAP_EN undefined:
  - misaligned_out is tied 0 and there is no misaligned check;
  - halfword loads use offset[1] only and word loads ignore offset[1:0];
  - all requests proceed to WAIT.

## Structure
- Shared package holds the funct3 load encodings (LB/LH/LW/LBU/LHU) and the FSM state enum.
- One sub-module, load_align: combinational byte/half select plus sign/zero extension. Inputs are funct3, offset and data; output is the 32-bit result. It is instantiated once, feeding the lu_output_out register.

## Test plan
- LB: addr 0x1003, data 0x80FF_0000, ack after 1 wait cycle. Expected: lu_output_out=0xFFFF_FF80, dmaddr_out=0x1000, one lu_valid_out pulse, stall_out high 3 cycles.
- LHU: addr 0x2002, data 0x8001_1234. Expected: 0x0000_8001. LH to the same address gives 0xFFFF_8001.
- LW: addr 0x3000 with ack in the first WAIT cycle. Expected: lu_valid_out exactly 2 cycles after the accept edge. A stray dm_ack_in in IDLE causes no change.
- Timeout: TIMEOUT_CYCLES=4, no ack. Expected: bus_err_out pulses once, dmrd_req_out drops, no lu_valid_out, stall releases.
- Misaligned LW at 0x4001 with the macro defined. Expected: misaligned_out pulse and no dmrd_req_out. With the macro undefined: a read of 0x4000 with full-word data returned.
- reset_in asserted in WAIT. Expected: dmrd_req_out=0 on the next edge, state IDLE, no valid; a subsequent request completes normally.
